// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_bus_arbiter
// Description : Round-robin arbiter that shares one registered WIDTH-bit
//               output bus between N_REQ producers. One valid/ready output
//               stage gives full back-to-back throughput. The grant pointer
//               advances only when a word is actually captured, so a waiting
//               requester cannot be starved.
// Ports       : i_clk       - clock, all state updates on the rising edge
//               i_rst       - asynchronous active-high reset
//               i_req       - per-requester request (held until granted)
//               i_data      - requester k data at [k*WIDTH +: WIDTH]
//               o_gnt       - one-hot grant, high only in the capture cycle
//               o_valid     - output register holds a word
//               o_data      - output word
//               o_src       - index of the requester that produced o_data
//               i_ready     - downstream accepts when o_valid & i_ready
//               o_xfer_cnt  - wrapping count of completed output transfers
// Revision    : 1.0 - initial release
// ============================================================================
module rr_bus_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*WIDTH-1:0]     i_data,
    output logic [N_REQ-1:0]           o_gnt,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(N_REQ)-1:0]   o_src,
    input  logic                       i_ready,
    output logic [15:0]                o_xfer_cnt
);

    localparam int SRC_W = $clog2(N_REQ);

    localparam logic [SRC_W-1:0] c_last_idx = SRC_W'(N_REQ - 1);
    localparam logic [SRC_W:0]   c_n_req    = (SRC_W + 1)'(N_REQ);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [SRC_W-1:0]   r_ptr;
    logic [SRC_W-1:0]   w_ptr_nxt;
    logic [SRC_W-1:0]   w_sel;
    logic               w_found;
    logic               w_load;
    logic [WIDTH-1:0]   w_sel_data;

    logic [WIDTH-1:0]   r_data;
    logic [SRC_W-1:0]   r_src;
    logic [15:0]        r_xfer_cnt;

    // ------------------------------------------------------------------------
    // Rotating-priority selection: scan ptr, ptr+1, ... wrapping at N_REQ and
    // take the first active request. The index is kept one bit wider than
    // SRC_W so the wrap subtraction cannot overflow for any legal N_REQ.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [SRC_W:0]   w_sum;
        logic [SRC_W-1:0] w_idx;
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (SRC_W + 1)'(i);
            if (w_sum >= c_n_req) begin
                w_sum = w_sum - c_n_req;
            end
            w_idx = w_sum[SRC_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_sel_data = i_data[w_sel*WIDTH +: WIDTH];

    // A capture happens when the output slot is free or being drained this
    // cycle, and somebody is asking. Reset suppresses it so o_gnt stays low.
    assign w_load = !i_rst && ((r_state == S_EMPTY) || i_ready) && w_found;

    assign w_ptr_nxt = (w_sel == c_last_idx) ? '0 : (w_sel + 1'b1);

    always_comb begin
        o_gnt = '0;
        if (w_load) begin
            o_gnt[w_sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output-stage FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: begin
                if (w_load) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                // A load while draining keeps the stage full (no bubble).
                if (w_load) begin
                    w_state_nxt = S_FULL;
                end else if (i_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Data path: word, source and pointer only change on a capture, which
    // also freezes them during backpressure.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_src  <= '0;
            r_ptr  <= '0;
        end else if (w_load) begin
            r_data <= w_sel_data;
            r_src  <= w_sel;
            r_ptr  <= w_ptr_nxt;
        end
    end

    // Completed-transfer counter, wraps naturally at 16 bits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_xfer_cnt <= '0;
        end else if ((r_state == S_FULL) && i_ready) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign o_valid    = (r_state == S_FULL);
    assign o_data     = r_data;
    assign o_src      = r_src;
    assign o_xfer_cnt = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_bus_arbiter
// Description : Self-checking bench for rr_bus_arbiter. A behavioural model
//               of the output slot, pointer and counter is compared against
//               the DUT every falling edge; directed sequences add literal
//               expectations, followed by a randomized phase and a counter
//               wrap sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_bus_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 3;
    localparam int SRC_W = $clog2(N_REQ);

    logic                     clk;
    logic                     rst;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*WIDTH-1:0]   data;
    logic [N_REQ-1:0]         gnt;
    logic                     valid;
    logic [WIDTH-1:0]         odata;
    logic [SRC_W-1:0]         src;
    logic                     ready;
    logic [15:0]              xfer_cnt;

    rr_bus_arbiter #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_data     (data),
        .o_gnt      (gnt),
        .o_valid    (valid),
        .o_data     (odata),
        .o_src      (src),
        .i_ready    (ready),
        .o_xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_src;
    int               m_ptr;
    logic [15:0]      m_cnt;

    // First requester found walking cyclically from the pointer, -1 if none.
    function automatic int pick_idx();
        for (int i = 0; i < N_REQ; i++) begin
            if (req[(m_ptr + i) % N_REQ]) return (m_ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] exp_gnt();
        logic [N_REQ-1:0] g;
        int k;
        g = '0;
        k = pick_idx();
        if (!rst && (!m_valid || ready) && k >= 0) g[k] = 1'b1;
        return g;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= 0;
            m_ptr   <= 0;
            m_cnt   <= '0;
        end else begin
            if (m_valid && ready) m_cnt <= m_cnt + 16'd1;
            if ((!m_valid || ready) && pick_idx() >= 0) begin
                m_valid <= 1'b1;
                m_data  <= data[pick_idx()*WIDTH +: WIDTH];
                m_src   <= pick_idx();
                m_ptr   <= (pick_idx() + 1) % N_REQ;
            end else if (ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        chk("m_gnt",   32'(gnt),      32'(exp_gnt()));
        chk("m_valid", 32'(valid),    32'(m_valid));
        chk("m_data",  32'(odata),    32'(m_data));
        chk("m_src",   32'(src),      32'(m_src));
        chk("m_cnt",   32'(xfer_cnt), 32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        req   = 3'b111;
        ready = 1'b0;
        data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid),    32'h0);
        chk("rst_data",  32'(odata),    32'h0);
        chk("rst_cnt",   32'(xfer_cnt), 32'h0);
        chk("rst_gnt",   32'(gnt),      32'h0);

        // Test 1: all three requesting, round-robin 0,1,2
        #1;
        rst   = 1'b0;
        ready = 1'b1;
        data  = {8'hFF, 8'h00, 8'hFF};
        #1 chk("t1_gnt0", 32'(gnt), 32'b001);
        @(negedge clk);
        chk("t1_src0",  32'(src),   32'd0);
        chk("t1_data0", 32'(odata), 32'hFF);
        @(negedge clk);
        chk("t1_src1",  32'(src),   32'd1);
        chk("t1_data1", 32'(odata), 32'h00);

        // Test 2: backpressure with o_src=1 for 3 cycles
        #1 ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t2_src_hold",  32'(src),   32'd1);
            chk("t2_data_hold", 32'(odata), 32'h00);
            chk("t2_gnt_zero",  32'(gnt),   32'h0);
        end
        #1 ready = 1'b1;
        #1 chk("t2_gnt_next", 32'(gnt), 32'b100);
        @(negedge clk);
        chk("t2_src2",  32'(src),      32'd2);
        chk("t2_data2", 32'(odata),    32'hFF);
        chk("t2_cnt",   32'(xfer_cnt), 32'd2);

        // Test 3: single requester 1 for 5 cycles
        #1 req = 3'b010;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_gnt", 32'(gnt), 32'b010);
            @(negedge clk);
            chk("t3_src", 32'(src), 32'd1);
        end
        chk("t3_cnt", 32'(xfer_cnt), 32'd7);

        // Test 4: ptr=2, req=101 -> 2 then 0; then req=001 -> 0
        #1 req = 3'b101;
        #1 chk("t4_gnt2", 32'(gnt), 32'b100);
        @(negedge clk);
        chk("t4_src2", 32'(src), 32'd2);
        #1 chk("t4_gnt0", 32'(gnt), 32'b001);
        @(negedge clk);
        chk("t4_src0", 32'(src), 32'd0);
        #1 req = 3'b001;
        #1 chk("t4_gnt0b", 32'(gnt), 32'b001);
        @(negedge clk);
        chk("t4_src0b", 32'(src), 32'd0);

        // Test 5: async reset while holding a word under backpressure
        #1 ready = 1'b0;
        @(negedge clk);
        chk("t5_pre_valid", 32'(valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t5_valid", 32'(valid),    32'h0);
        chk("t5_data",  32'(odata),    32'h0);
        chk("t5_cnt",   32'(xfer_cnt), 32'h0);
        chk("t5_gnt",   32'(gnt),      32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        chk("t5_post_valid", 32'(valid), 32'h0);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            rst   = ($urandom_range(0, 199) == 0);
            req   = N_REQ'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            data  = (N_REQ*WIDTH)'($urandom);
        end

        // Test 6: counter wrap
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        rst   = 1'b0;
        req   = 3'b111;
        ready = 1'b1;
        for (int c = 0; c < 70000 && xfer_cnt != 16'hFFFE; c++) @(negedge clk);
        chk("t6_preload", 32'(xfer_cnt), 32'hFFFE);
        @(negedge clk);
        chk("t6_cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
        @(negedge clk);
        chk("t6_cnt_0000", 32'(xfer_cnt), 32'h0000);
        @(negedge clk);
        chk("t6_cnt_0001", 32'(xfer_cnt), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
